darkriscv_dbus_wb_bridge: RTL



---
 rtl/darkriscv_dbus_wb_bridge_if.sv | 48 ++++
 rtl/darkriscv_dbus_wb_bridge.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/darkriscv_dbus_wb_bridge_if.sv
// Bus bundles for the darkriscv data-port bridge: the core-side request/ack port and the
// single-transfer Wishbone port.
interface darkriscv_dbus_core_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  core_req_i;
  logic                  core_we_i;
  logic [DATA_W/8-1:0]   core_be_i;
  logic [ADDR_W-1:0]     core_addr_i;
  logic [DATA_W-1:0]     core_wdata_i;
  logic [DATA_W-1:0]     core_rdata_o;
  logic                  core_ack_o;
  logic                  core_err_o;

  modport master (
    output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    input  core_rdata_o, core_ack_o, core_err_o
  );
  modport slave (
    input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    output core_rdata_o, core_ack_o, core_err_o
  );
endinterface

interface darkriscv_dbus_wb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [DATA_W/8-1:0]   wb_sel_o;
  logic [ADDR_W-1:0]     wb_addr_o;
  logic [DATA_W-1:0]     wb_data_o;
  logic [DATA_W-1:0]     wb_data_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
    input  wb_data_i, wb_ack_i, wb_err_i
  );
  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
    output wb_data_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/darkriscv_dbus_wb_bridge.sv
// darkriscv data port to single-transfer Wishbone bridge with alignment check, bus timeout
// and saturating error counter. Define DBRIDGE_ACK_REG_EN to register the slave response.
module darkriscv_dbus_wb_bridge #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  darkriscv_dbus_core_if.slave core,
  darkriscv_dbus_wb_if.master  wb,
  output logic [ERRCNT_W-1:0] err_count_o
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                state_reg, state_next;
  logic                  err_reg, err_next;
  logic                  we_reg;
  logic [BE_W-1:0]       be_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [DATA_W-1:0]     rdata_reg;
  logic [31:0]           tmo_reg;
  logic [ERRCNT_W-1:0]   errcnt_reg;

  logic                  bus_live;
  logic                  rsp_ack;
  logic                  rsp_err;
  logic [DATA_W-1:0]     rsp_data;
  logic                  hold;
  logic                  misaligned;
  logic                  tmo_fire;

  assign misaligned = (core.core_addr_i[1:0] != 2'b00) || (core.core_be_i == '0);

`ifdef DBRIDGE_ACK_REG_EN
  logic              seen_reg;
  logic              ack_q_reg;
  logic              err_q_reg;
  logic [DATA_W-1:0] data_q_reg;
  logic              raw_hit;

  // Only responses sampled while the strobe is up are registered, so stale
  // or spurious acks can never reach the FSM.
  assign raw_hit = (state_reg == BUS) && !seen_reg && (wb.wb_ack_i || wb.wb_err_i);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_reg   <= 1'b0;
      ack_q_reg  <= 1'b0;
      err_q_reg  <= 1'b0;
      data_q_reg <= '0;
    end else begin
      ack_q_reg <= raw_hit && wb.wb_ack_i;
      err_q_reg <= raw_hit && wb.wb_err_i;
      if (raw_hit)
        data_q_reg <= wb.wb_data_i;
      if (state_reg != BUS)
        seen_reg <= 1'b0;
      else if (raw_hit)
        seen_reg <= 1'b1;
    end
  end

  assign bus_live = (state_reg == BUS) && !seen_reg;
  assign rsp_ack  = ack_q_reg;
  assign rsp_err  = err_q_reg;
  assign rsp_data = data_q_reg;
  assign hold     = seen_reg || raw_hit;
`else
  assign bus_live = (state_reg == BUS);
  assign rsp_ack  = wb.wb_ack_i;
  assign rsp_err  = wb.wb_err_i;
  assign rsp_data = wb.wb_data_i;
  assign hold     = wb.wb_ack_i || wb.wb_err_i;
`endif

  assign tmo_fire = (TIMEOUT != 0) && !hold && (tmo_reg == TMO_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (core.core_req_i) begin
          state_next = misaligned ? RESP : BUS;
          err_next   = misaligned;
        end
      end
      BUS: begin
        if (rsp_err) begin
          state_next = RESP;
          err_next   = 1'b1;
        end else if (rsp_ack) begin
          state_next = RESP;
          err_next   = 1'b0;
        end else if (tmo_fire) begin
          state_next = RESP;
          err_next   = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wb.wb_cyc_o       = bus_live;
    wb.wb_stb_o       = bus_live;
    wb.wb_we_o        = bus_live && we_reg;
    wb.wb_sel_o       = bus_live ? be_reg : '0;
    wb.wb_addr_o      = bus_live ? addr_reg : '0;
    wb.wb_data_o      = (bus_live && we_reg) ? wdata_reg : '0;
    core.core_ack_o   = (state_reg == RESP);
    core.core_err_o   = (state_reg == RESP) && err_reg;
    core.core_rdata_o = rdata_reg;
    err_count_o       = errcnt_reg;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg    <= 1'b0;
      we_reg     <= 1'b0;
      be_reg     <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      tmo_reg    <= '0;
      errcnt_reg <= '0;
    end else begin
      err_reg <= err_next;
      if (state_reg == IDLE && core.core_req_i) begin
        we_reg    <= core.core_we_i;
        be_reg    <= core.core_be_i;
        addr_reg  <= core.core_addr_i;
        wdata_reg <= core.core_wdata_i;
      end
      if (state_reg != BUS)
        tmo_reg <= '0;
      else if (!hold)
        tmo_reg <= tmo_reg + 32'd1;
      if (state_reg == BUS && rsp_ack && !rsp_err && !we_reg)
        rdata_reg <= rsp_data;
      // Counted on entry to RESP so the new count is visible alongside core_ack_o.
      if (state_reg != RESP && state_next == RESP && err_next && errcnt_reg != '1)
        errcnt_reg <= errcnt_reg + 1'b1;
    end
  end

endmodule
